// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared DLX pipeline types and forwarding constants
package dlx_pkg;

    localparam int DLX_REGW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [DLX_REGW-1:0] REG_ZERO = '0;

    // Destination record for an instruction in flight
    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic [DLX_REGW-1:0] rd;
    } slot_t;

    // EX holds the destination plus its own sources for forwarding;
    // only EX needs the load flag, since a load can never be in MEM
    // while its consumer is in EX (load-use stall prevents it)
    typedef struct packed {
        slot_t               dst;
        logic                load;
        logic [DLX_REGW-1:0] rs1;
        logic [DLX_REGW-1:0] rs2;
        logic                use1;
        logic                use2;
    } ex_slot_t;

    // True when slot s will write register r; R0 never matches
    function automatic logic slot_match(slot_t s, logic [DLX_REGW-1:0] r);
        return s.valid & s.regwrite & (s.rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand forwarding priority select
module hazard_fwd_sel
    import dlx_pkg::*;
(
    input  logic                ex_valid,
    input  logic                use_rs,
    input  logic [DLX_REGW-1:0] rs,
    input  slot_t               mem_s,
    input  slot_t               wb_s,
    output logic [1:0]          sel
);

    // MEM result is newer than WB, so it wins when both match
    always_comb begin
        sel = FWD_RF;
        if (ex_valid) begin
            if (use_rs && slot_match(mem_s, rs)) begin
                sel = FWD_MEM;
            end else if (slot_match(wb_s, rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - DLX interlock, forwarding and multiply-freeze controller
module hazard_ctrl
    import dlx_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int REGW       = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_load,
    input  logic            id_mul,
    input  logic            ex_redirect,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mul_busy
);

    localparam logic [3:0] MUL_START = 4'(MUL_CYCLES - 1);

    ex_slot_t   ex_s;
    slot_t      mem_s;
    slot_t      wb_s;
    logic [3:0] mul_cnt;

    logic busy;
    logic load_use;
    logic id_take;

    assign busy     = (mul_cnt != 4'd0);
    assign load_use = id_valid & ex_s.load &
                      ((id_use_rs1 & slot_match(ex_s.dst, id_rs1)) |
                       (id_use_rs2 & slot_match(ex_s.dst, id_rs2)));
    assign id_take  = id_valid & ~idex_bubble;

    // Control priority: multiply freeze, then redirect, then load-use
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mul_busy    = 1'b0;
        if (busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            mul_busy   = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    // Slot pipeline advance and multiply countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_s    <= '0;
            mem_s   <= '0;
            wb_s    <= '0;
            mul_cnt <= 4'd0;
        end else if (busy) begin
            mul_cnt <= mul_cnt - 4'd1;
        end else begin
            wb_s  <= mem_s;
            mem_s <= ex_s.dst;
            if (id_take) begin
                ex_s.dst.valid    <= 1'b1;
                ex_s.dst.regwrite <= id_regwrite;
                ex_s.dst.rd       <= id_rd;
                ex_s.load         <= id_load;
                ex_s.rs1          <= id_rs1;
                ex_s.rs2          <= id_rs2;
                ex_s.use1         <= id_use_rs1;
                ex_s.use2         <= id_use_rs2;
                if (id_mul) begin
                    mul_cnt <= MUL_START;
                end
            end else begin
                ex_s <= '0;
            end
        end
    end

    hazard_fwd_sel u_fwd_a (
        .ex_valid (ex_s.dst.valid),
        .use_rs   (ex_s.use1),
        .rs       (ex_s.rs1),
        .mem_s    (mem_s),
        .wb_s     (wb_s),
        .sel      (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .ex_valid (ex_s.dst.valid),
        .use_rs   (ex_s.use2),
        .rs       (ex_s.rs2),
        .mem_s    (mem_s),
        .wb_s     (wb_s),
        .sel      (fwd_b)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Interlock and forwarding controller for the 5-stage DLX pipeline.
- Sits beside the register-decode stage and tracks the destinations of instructions in flight in EX, MEM and WB.
- Drives stall, bubble and flush controls for IF/ID and ID/EX, and forwarding selects for the EX operand muxes.
- Sequences a multi-cycle multiply by freezing the pipe until the multiply completes.

Parameters:
- MUL_CYCLES, 4, total EX-stage occupancy of a multiply in cycles (legal range 1..15).
- REGW, 5, register index width (32 GPRs).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  the IF/ID register holds a real instruction.
- id_rs1  in  REGW  source 1 index of the instruction in ID.
- id_rs2  in  REGW  source 2 index of the instruction in ID.
- id_use_rs1  in  1  the ID instruction reads rs1.
- id_use_rs2  in  1  the ID instruction reads rs2.
- id_rd  in  REGW  destination of the ID instruction (after regdst/jal selection).
- id_regwrite  in  1  the ID instruction writes a register.
- id_load  in  1  the ID instruction is a load (mem2reg).
- id_mul  in  1  the ID instruction is a multi-cycle multiply.
- ex_redirect  in  1  a branch or jump resolved taken in EX this cycle.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold the IF/ID register.
- ifid_flush  out  1  clear the IF/ID register to a NOP.
- idex_bubble  out  1  load a NOP (control signals zeroed) into ID/EX.
- fwd_a  out  2  EX operand A source: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
- fwd_b  out  2  EX operand B source, same encoding as fwd_a.
- mul_busy  out  1  a multiply occupies EX and the pipe is frozen.

Behaviour:
- State:
  - Three slots ex_s, mem_s and wb_s. Each holds {valid, rd, regwrite, load}; ex_s also holds {rs1, rs2, use1, use2}.
  - One down-counter mul_cnt (4 bits).
- Reset: all slots invalid, mul_cnt = 0, every output 0. Reset mid-multiply abandons the multiply immediately.
- R0 is never a hazard source: any rd = 0 counts as a non-write for matching purposes.
- Define the following terms:
  - match(s, r): s.valid & s.regwrite & s.rd == r & r != 0.
  - load_use: id_valid & ex_s.load & ((id_use_rs1 & match(ex_s, id_rs1)) | (id_use_rs2 & match(ex_s, id_rs2))).
  - busy: mul_cnt != 0.
- Control priority, evaluated combinationally each cycle:
  1. busy: pc_stall = 1, ifid_stall = 1, mul_busy = 1, idex_bubble = 0, ifid_flush = 0. All slots hold and ex_redirect is ignored. mul_cnt decrements.
  2. ex_redirect: ifid_flush = 1 and idex_bubble = 1. This overrides load_use, and the wrong-path ID instruction is discarded.
  3. load_use: pc_stall = 1, ifid_stall = 1, idex_bubble = 1. This gives exactly one bubble, because after one cycle the load sits in MEM.
  4. Otherwise all outputs 0 and the pipe advances.
- Slot advance (whenever not busy):
  - wb_s <= mem_s and mem_s <= ex_s.
  - ex_s <= the ID fields if (id_valid & !idex_bubble); otherwise ex_s becomes invalid.
- Multiply start: on the edge where an id_mul instruction enters ex_s, mul_cnt <= MUL_CYCLES-1.
  - With MUL_CYCLES = 1 there is no freeze.
  - The freeze lasts MUL_CYCLES-1 cycles. On the last frozen cycle mul_cnt = 1, and the next cycle advances normally.
- Forwarding, combinational, for the instruction in ex_s:
  - fwd_a = 01 if ex_s.use1 & match(mem_s, ex_s.rs1).
  - Else fwd_a = 10 if match(wb_s, ex_s.rs1).
  - Else fwd_a = 00.
  - MEM has priority over WB. fwd_b is computed the same way on rs2/use2.
  - If ex_s is invalid, fwd_a = fwd_b = 00.
- A load in mem_s matching ex_s cannot occur because of the load_use stall. Verification flags it as an assertion.
- An ID read of the register being written by WB in the same cycle is resolved by the register file (write-before-read). This block raises no stall for it.
- Outputs are pure functions of the current state and inputs. There is no extra latency beyond the one-cycle slot pipeline.

Decomposition:
- Shared package (dlx_pkg) holds:
  - the forwarding-select constants FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - the in-flight slot struct;
  - REG_ZERO = 0.
- One sub-module, hazard_fwd_sel: purely combinational per-operand forwarding priority, instantiated twice (A and B).

Test Plan:
- Back-to-back ALU, `add r1,r2,r3` then `sub r4,r1,r5` → next cycle fwd_a = 01, no stall. One cycle later a third `or r6,r1,r0` → fwd_a = 10.
- Load-use, `lw r1,0(r2)` then `add r3,r1,r1` → exactly one cycle of pc_stall = ifid_stall = idex_bubble = 1; then fwd_a = fwd_b = 10, no second stall.
- R0 writes, `add r0,r2,r3` then `add r4,r0,r0` → fwd_a = fwd_b = 00 and no stall. The same holds with `lw r0` followed by a reader.
- Taken branch in EX coinciding with load_use in ID → ifid_flush = 1 and idex_bubble = 1, pc_stall = 0. The following cycle has no residual stall.
- Multiply with MUL_CYCLES = 4, `mul r7,r1,r2` → mul_busy = 1 for 3 cycles with slots frozen and ex_redirect ignored. The dependent `add r8,r7,r7` then gets fwd_a = 01.
- Reset asserted on the second frozen multiply cycle → next cycle all outputs 0 and mul_busy = 0. A fresh `lw` followed by a dependent stalls normally.
